// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, address field slices and FSM encoding for the refill controller
package cache_pkg;
  localparam int ADDR_W    = 12;
  localparam int LINE_W    = 128;
  localparam int BEAT_W    = 32;
  localparam int SET_W     = 3;
  localparam int TAG_W     = 5;
  localparam int NUM_BEATS = LINE_W / BEAT_W;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int BEAT_SH   = $clog2(BEAT_W);

  localparam int OFF_W      = 4;
  localparam int WORD_LSB   = 2;
  localparam int SET_LSB    = 4;
  localparam int TAG_LSB    = 7;
  localparam int LINE_ADDR_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/lru_table.sv
// rtl/lru_table.sv - per-set 1-bit LRU; the bit names the next victim way
module lru_table
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] rd_set_i,
  output logic             rd_way_o,
  input  logic             acc_en_i,
  input  logic [SET_W-1:0] acc_set_i,
  input  logic             acc_way_i,
  input  logic             fill_en_i,
  input  logic [SET_W-1:0] fill_set_i,
  input  logic             fill_way_i
);
  localparam int NUM_SETS = 1 << SET_W;

  logic [NUM_SETS-1:0] lru_q, lru_d;

  // Fill write is applied last so it overrides a same-set access update.
  always_comb begin
    lru_d = lru_q;
    if (acc_en_i)  lru_d[acc_set_i]  = ~acc_way_i;
    if (fill_en_i) lru_d[fill_set_i] = ~fill_way_i;
  end

  always_ff @(posedge clk) begin
    if (rst) lru_q <= '0;
    else     lru_q <= lru_d;
  end

  assign rd_way_o = lru_q[rd_set_i];
endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss refill: 4-beat burst fetch, line assembly, LRU victim choice, 1-cycle fill
// Optional build macro CRITICAL_WORD_FIRST_EN: wrapped burst order plus crit_valid/crit_word outputs.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_valid,
  input  logic [ADDR_W-1:0]      miss_addr,
  output logic                   miss_ready,
  input  logic                   acc_valid,
  input  logic [SET_W-1:0]       acc_set,
  input  logic                   acc_way,
  output logic                   mem_req,
  output logic [LINE_ADDR_W-1:0] mem_line,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [BEAT_W-1:0]      mem_rdata,
  output logic                   fill_valid,
  output logic [SET_W-1:0]       fill_set,
  output logic                   fill_way,
  output logic [TAG_W-1:0]       fill_tag,
  output logic [LINE_W-1:0]      fill_line,
  output logic                   busy
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                   crit_valid,
  output logic [BEAT_W-1:0]      crit_word
`endif
);
  state_e                 state_q, state_d;
  logic [LINE_ADDR_W-1:0] line_addr_q, line_addr_d;
  logic                   victim_q, victim_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [CNT_W-1:0]       beat_ptr;
  logic                   lru_way;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [CNT_W-1:0] start_q, start_d;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[WORD_LSB-1:0];
  assign beat_ptr         = start_q + cnt_q;
  assign crit_valid       = (state_q == ST_FILL) && mem_rvalid && (cnt_q == '0);
  assign crit_word        = mem_rdata;
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];
  assign beat_ptr         = cnt_q;
`endif

  lru_table u_lru (
    .clk        (clk),
    .rst        (rst),
    .rd_set_i   (miss_addr[SET_LSB +: SET_W]),
    .rd_way_o   (lru_way),
    .acc_en_i   (acc_valid),
    .acc_set_i  (acc_set),
    .acc_way_i  (acc_way),
    .fill_en_i  (state_q == ST_DONE),
    .fill_set_i (fill_set),
    .fill_way_i (victim_q)
  );

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
`ifdef CRITICAL_WORD_FIRST_EN
    start_d     = start_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          line_addr_d = miss_addr[ADDR_W-1:OFF_W];
          victim_d    = lru_way;
          cnt_d       = '0;
`ifdef CRITICAL_WORD_FIRST_EN
          start_d     = miss_addr[WORD_LSB +: CNT_W];
`endif
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (mem_rvalid) begin
          line_d[{beat_ptr, {BEAT_SH{1'b0}}} +: BEAT_W] = mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_BEATS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      victim_q    <= 1'b0;
      cnt_q       <= '0;
      line_q      <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q     <= start_d;
`endif
    end
  end

  assign miss_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_line   = line_addr_q;
  assign fill_valid = (state_q == ST_DONE);
  assign fill_set   = line_addr_q[SET_LSB-OFF_W +: SET_W];
  assign fill_tag   = line_addr_q[TAG_LSB-OFF_W +: TAG_W];
  assign fill_way   = victim_q;
  assign fill_line  = line_q;
endmodule
